// File: rtl/float_minmax_reduce.sv
// -----------------------------------------------------------------------------
// float_minmax_reduce
//
// Streaming min/max reduction for the GPU setup path. A packet of floats
// arrives one beat at a time; the unit tracks the minimum and maximum values,
// the zero-based index of each, and the element count (modulo 2^IDX_W).
// A single greater-than float comparator is time-shared between the max test
// (CMPHI) and the min test (CMPLO).
//
// Optional build macro:
//   FLOAT_MINMAX_REDUCE_DUAL_CMP_EN - instantiate a second comparator so that
//   the max and min updates both happen in CMPHI (2 cycles per non-first beat
//   instead of 3). CMPLO is never entered. Results are identical.
//
// Handshakes: a beat moves on in_valid && in_ready; a result moves on
// out_valid && out_ready. A valid source holds its payload stable until the
// handshake cycle, and ready never depends on the same-cycle valid.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    input beat handshake
//   in_data, in_last     float word (sign in MSB) and end-of-packet flag
//   out_valid/out_ready  result handshake
//   out_min, out_max     reduced values
//   out_min_idx/_max_idx index of each reduced value within the packet
//   out_count            number of elements in the packet, modulo 2^IDX_W
// -----------------------------------------------------------------------------
module float_minmax_reduce #(
   parameter int EXPONENT = 6,
   parameter int MANTISSA = 11,
   parameter int IDX_W    = 8,
   localparam int W       = EXPONENT + MANTISSA + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_min,
   output logic [W-1:0]     out_max,
   output logic [IDX_W-1:0] out_min_idx,
   output logic [IDX_W-1:0] out_max_idx,
   output logic [IDX_W-1:0] out_count
);

   typedef enum logic [2:0] {
      S_FIRST = 3'd0,
      S_NEXT  = 3'd1,
      S_CMPHI = 3'd2,
      S_CMPLO = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     min_q, min_d;
   logic [W-1:0]     max_q, max_d;
   logic [IDX_W-1:0] min_idx_q, min_idx_d;
   logic [IDX_W-1:0] max_idx_q, max_idx_d;
   logic [IDX_W-1:0] count_q, count_d;
   logic [W-1:0]     hold_q, hold_d;
   logic             last_q, last_d;
   logic             out_valid_q, out_valid_d;

   logic             in_fire;
   logic [W-1:0]     cmp_a, cmp_b;
   logic             cmp_gt;

   // Float ordering: sign decides first; among negatives the smaller
   // magnitude is greater, and equal negatives report true so that a later
   // equal negative value takes over the stored index.
   function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
      logic mag_gt;
      mag_gt = (a[W-2:0] > b[W-2:0]);
      if ((a == '0) && (b == '0)) begin
         gt = 1'b0;
      end else if (a[W-1] != b[W-1]) begin
         gt = ~a[W-1];
      end else if (!a[W-1]) begin
         gt = mag_gt;
      end else begin
         gt = ~mag_gt;
      end
   endfunction

   assign in_ready = (state_q == S_FIRST) || (state_q == S_NEXT);
   assign in_fire  = in_valid && in_ready;

`ifdef FLOAT_MINMAX_REDUCE_DUAL_CMP_EN
   logic cmp_lo_gt;

   assign cmp_a     = hold_q;
   assign cmp_b     = max_q;
   assign cmp_gt    = gt(cmp_a, cmp_b);
   assign cmp_lo_gt = gt(min_q, hold_q);
`else
   // The one comparator sees (hold, max) in CMPHI and (min, hold) otherwise.
   always_comb begin
      cmp_a = min_q;
      cmp_b = hold_q;
      if (state_q == S_CMPHI) begin
         cmp_a = hold_q;
         cmp_b = max_q;
      end
   end

   assign cmp_gt = gt(cmp_a, cmp_b);
`endif

   always_comb begin
      state_d     = state_q;
      min_d       = min_q;
      max_d       = max_q;
      min_idx_d   = min_idx_q;
      max_idx_d   = max_idx_q;
      count_d     = count_q;
      hold_d      = hold_q;
      last_d      = last_q;
      out_valid_d = out_valid_q;

      case (state_q)
         S_FIRST: begin
            if (in_fire) begin
               min_d     = in_data;
               max_d     = in_data;
               min_idx_d = '0;
               max_idx_d = '0;
               count_d   = IDX_W'(1);
               if (in_last) begin
                  state_d     = S_OUT;
                  out_valid_d = 1'b1;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end

         S_NEXT: begin
            if (in_fire) begin
               hold_d  = in_data;
               last_d  = in_last;
               state_d = S_CMPHI;
            end
         end

         S_CMPHI: begin
            // count_q is the index of the beat currently in hold_q.
            if (cmp_gt) begin
               max_d     = hold_q;
               max_idx_d = count_q;
            end
`ifdef FLOAT_MINMAX_REDUCE_DUAL_CMP_EN
            if (cmp_lo_gt) begin
               min_d     = hold_q;
               min_idx_d = count_q;
            end
            count_d = count_q + IDX_W'(1);
            if (last_q) begin
               state_d     = S_OUT;
               out_valid_d = 1'b1;
            end else begin
               state_d = S_NEXT;
            end
`else
            state_d = S_CMPLO;
`endif
         end

         S_CMPLO: begin
`ifdef FLOAT_MINMAX_REDUCE_DUAL_CMP_EN
            state_d = S_NEXT;
`else
            if (cmp_gt) begin
               min_d     = hold_q;
               min_idx_d = count_q;
            end
            count_d = count_q + IDX_W'(1);
            if (last_q) begin
               state_d     = S_OUT;
               out_valid_d = 1'b1;
            end else begin
               state_d = S_NEXT;
            end
`endif
         end

         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_FIRST;
            end
         end

         default: begin
            state_d     = S_FIRST;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_FIRST;
         min_q       <= '0;
         max_q       <= '0;
         min_idx_q   <= '0;
         max_idx_q   <= '0;
         count_q     <= '0;
         hold_q      <= '0;
         last_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         min_q       <= min_d;
         max_q       <= max_d;
         min_idx_q   <= min_idx_d;
         max_idx_q   <= max_idx_d;
         count_q     <= count_d;
         hold_q      <= hold_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_min     = min_q;
   assign out_max     = max_q;
   assign out_min_idx = min_idx_q;
   assign out_max_idx = max_idx_q;
   assign out_count   = count_q;

endmodule

// File: tb/tb_float_minmax_reduce.sv
// -----------------------------------------------------------------------------
// tb_float_minmax_reduce
//
// Directed and randomized packets for float_minmax_reduce. Expected results
// come from a reference model that maps each float to an integer ordering key
// and reduces the packet with plain loops; results are queued and checked in
// order as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_float_minmax_reduce;

   localparam int EXPONENT = 6;
   localparam int MANTISSA = 11;
   localparam int IDX_W    = 8;
   localparam int W        = EXPONENT + MANTISSA + 1;
`ifdef FLOAT_MINMAX_REDUCE_DUAL_CMP_EN
   localparam int CMP_CYC  = 2;
`else
   localparam int CMP_CYC  = 3;
`endif

   typedef struct packed {
      logic [W-1:0]     mn;
      logic [IDX_W-1:0] mn_idx;
      logic [W-1:0]     mx;
      logic [IDX_W-1:0] mx_idx;
      logic [IDX_W-1:0] cnt;
   } res_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_min;
   logic [W-1:0]     out_max;
   logic [IDX_W-1:0] out_min_idx;
   logic [IDX_W-1:0] out_max_idx;
   logic [IDX_W-1:0] out_count;

   float_minmax_reduce #(
      .EXPONENT (EXPONENT),
      .MANTISSA (MANTISSA),
      .IDX_W    (IDX_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_min     (out_min),
      .out_max     (out_max),
      .out_min_idx (out_min_idx),
      .out_max_idx (out_max_idx),
      .out_count   (out_count)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] pkt [0:299];
   logic [W-1:0] pool [0:3];
   res_t         exp_q [$];
   int           n_checks = 0;
   int           n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // Integer key giving the float order: +0 ranks above -0, negatives by
   // negated magnitude.
   function automatic int fkey(input logic [W-1:0] v);
      if (v[W-1]) return -int'(v[W-2:0]);
      return int'(v[W-2:0]) + 1;
   endfunction

   // A later element replaces the stored one when strictly beyond it, or
   // when equal and negative.
   function automatic res_t model(input int len);
      res_t r;
      r.mn     = pkt[0];
      r.mx     = pkt[0];
      r.mn_idx = '0;
      r.mx_idx = '0;
      for (int i = 1; i < len; i++) begin
         if (fkey(pkt[i]) > fkey(r.mx) || (fkey(pkt[i]) == fkey(r.mx) && pkt[i][W-1])) begin
            r.mx     = pkt[i];
            r.mx_idx = IDX_W'(i);
         end
         if (fkey(pkt[i]) < fkey(r.mn) || (fkey(pkt[i]) == fkey(r.mn) && pkt[i][W-1])) begin
            r.mn     = pkt[i];
            r.mn_idx = IDX_W'(i);
         end
      end
      r.cnt = IDX_W'(len);
      return r;
   endfunction

   function automatic res_t dut_res();
      res_t r;
      r.mn     = out_min;
      r.mn_idx = out_min_idx;
      r.mx     = out_max;
      r.mx_idx = out_max_idx;
      r.cnt    = out_count;
      return r;
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      case ($urandom_range(0, 4))
         0, 1:    w = pool[$urandom_range(0, 3)];
         2:       w = $urandom_range(0, 1) ? {1'b1, {(W-1){1'b0}}} : '0;
         default: w = W'($urandom);
      endcase
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Enters and leaves 1 time unit after a rising edge; acc is the cycle
   // stamp just after the accepting edge.
   task automatic send_beat(input logic [W-1:0] d, input logic last, output int acc);
      int guard;
      bit done;
      guard    = 0;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!done) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
         if (!done) begin
            guard++;
            if (guard > 40) begin
               check("in_ready_timeout", in_ready, 1);
               done = 1'b1;
            end
         end
      end
      acc      = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic recv_result(input int stall);
      res_t exp;
      res_t snap;
      int   guard;
      guard = 0;
      while (!out_valid && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("sb_depth", exp_q.size(), 1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      if (!out_valid) begin
         check("out_valid_timeout", out_valid, 1);
         return;
      end
      check("out_min", out_min, exp.mn);
      check("out_min_idx", out_min_idx, exp.mn_idx);
      check("out_max", out_max, exp.mx);
      check("out_max_idx", out_max_idx, exp.mx_idx);
      check("out_count", out_count, exp.cnt);
      snap = dut_res();
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1;
         check("stall_hold", dut_res(), snap);
         check("stall_valid", out_valid, 1);
         check("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("post_hs_in_ready", in_ready, 1);
      check("post_hs_out_valid", out_valid, 0);
   endtask

   task automatic run_packet(input int len, input int gap_max, input int stall, input bit check_rate);
      int acc;
      int prev;
      int lat;
      prev = 0;
      for (int i = 0; i < len; i++) begin
         if (gap_max > 0) idle($urandom_range(0, gap_max));
         send_beat(pkt[i], (i == len - 1), acc);
         if (check_rate && i > 0) check("beat_spacing", acc - prev, (i == 1) ? 1 : CMP_CYC);
         prev = acc;
      end
      exp_q.push_back(model(len));
      if (check_rate) begin
         lat = (len == 1) ? 1 : CMP_CYC;
         for (int k = 0; k < lat - 1; k++) begin
            check("lat_busy", out_valid, 0);
            @(posedge clk);
            #1;
         end
         check("lat_done", out_valid, 1);
      end
      recv_result(stall);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int acc;
      int len;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_outputs", dut_res(), 0);

      // single beat 1.0
      pkt[0] = 18'h0F800;
      run_packet(1, 0, 0, 1);

      // mixed sequence with in_valid held high
      pkt[0] = 18'h0F800; pkt[1] = 18'h30000; pkt[2] = 18'h10000; pkt[3] = 18'h0F000;
      run_packet(4, 0, 0, 1);

      // ties and signed zeros
      pkt[0] = 18'h0F800; pkt[1] = 18'h0F800;
      run_packet(2, 0, 0, 1);
      pkt[0] = 18'h2F800; pkt[1] = 18'h2F800;
      run_packet(2, 0, 0, 1);
      pkt[0] = 18'h20000; pkt[1] = 18'h00000;
      run_packet(2, 0, 0, 1);
      pkt[0] = 18'h00000; pkt[1] = 18'h00000; pkt[2] = 18'h20000; pkt[3] = 18'h20000;
      run_packet(4, 0, 0, 1);

      // result back-pressure for 5 cycles
      pkt[0] = 18'h11000; pkt[1] = 18'h31000; pkt[2] = 18'h0E000;
      run_packet(3, 0, 5, 0);

      // reset in the final compare cycle of the 3rd beat
      send_beat(18'h0F800, 1'b0, acc);
      send_beat(18'h30000, 1'b0, acc);
      send_beat(18'h10000, 1'b0, acc);
      repeat (CMP_CYC - 2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_outputs", dut_res(), 0);
      idle(4);
      check("abort_no_result", out_valid, 0);
      pkt[0] = 18'h2F800;
      run_packet(1, 0, 0, 1);

      // count wraps at 256
      for (int i = 0; i < 256; i++) pkt[i] = 18'h0F800;
      run_packet(256, 0, 0, 0);

      // randomized packets
      for (int p = 0; p < 40; p++) begin
         for (int j = 0; j < 4; j++) pool[j] = W'($urandom);
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) pkt[i] = rand_word();
         run_packet(len, (p % 2 == 0) ? 0 : 3, $urandom_range(0, 3), (p % 2 == 0));
      end

      // a longer packet that also wraps the count
      for (int j = 0; j < 4; j++) pool[j] = W'($urandom);
      for (int i = 0; i < 260; i++) pkt[i] = rand_word();
      run_packet(260, 0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
